// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
package dram_port_arbiter_pkg;

    localparam int unsigned ADR_W  = 32;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned MASK_W = 16;

    // 1 = byte preserved, so a read leaves every byte untouched
    localparam logic [MASK_W-1:0] RD_MASK = 16'hffff;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_CPU = 2'd1,
        BUSY_MON = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dram_port_arbiter_mon_req_slot.sv
// Turns a one-cycle monitor request pulse into a pending flag plus payload;
// a pulse into an occupied slot is dropped and flagged (sticky) as overflow.
module mon_req_slot
    import dram_port_arbiter_pkg::*;
#(
    parameter int unsigned PAY_W = ADR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse,
    input  logic [PAY_W-1:0] pay_in,
    input  logic             clear,
    output logic             pend,
    output logic [PAY_W-1:0] payload,
    output logic             ovf
);

    // NOTE: the payload is reset along with the flag so that no stale address
    //       or data is visible after reset; it is a plain register, not RAM.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= 1'b0;
            payload <= '0;
            ovf     <= 1'b0;
        end else begin
            // A clear in the same cycle frees the slot first, so the pulse is kept.
            if (pulse && pend && !clear) begin
                ovf <= 1'b1;
            end else if (pulse) begin
                pend    <= 1'b1;
                payload <= pay_in;
            end else if (clear) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing the 128-bit data-RAM port between the CPU
// data-cache path and the UART monitor, one transaction outstanding at a time.
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter int unsigned TMO_CYC = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mon_rd_req,
    input  logic [ADR_W-1:0]    mon_radr,
    input  logic                mon_wen,
    input  logic [ADR_W-1:0]    mon_wadr,
    input  logic [DATA_W-1:0]   mon_wdata,
    input  logic [MASK_W-1:0]   mon_mask,
    output logic                mon_read_valid,
    output logic [DATA_W-1:0]   mon_rdata,
    output logic                mon_finish_wresp,
    output logic                mon_ovf,
    input  logic                dc_req,
    input  logic                dc_we,
    input  logic [ADR_W-1:0]    dc_adr,
    input  logic [DATA_W-1:0]   dc_wdata,
    input  logic [MASK_W-1:0]   dc_mask,
    output logic                dc_done,
    output logic [DATA_W-1:0]   dc_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADR_W-1:0]    mem_adr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [MASK_W-1:0]   mem_mask,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                tmo_err
);

    localparam int unsigned WR_PAY_W = ADR_W + DATA_W + MASK_W;
    localparam int unsigned CNT_W    = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    arb_state_t          state;
    logic                last_mon;   // 1 = monitor won the previous grant
    logic [CNT_W-1:0]    cnt;

    logic                rd_pend, wr_pend, rd_ovf, wr_ovf;
    logic                rd_clear, wr_clear;
    logic [ADR_W-1:0]    rd_adr, wr_adr;
    logic [WR_PAY_W-1:0] wr_payload;
    logic [DATA_W-1:0]   wr_data;
    logic [MASK_W-1:0]   wr_mask;

    logic                cpu_cand, mon_pend, grant_mon, grant_cpu, wdog_hit;

    mon_req_slot #(.PAY_W(ADR_W)) u_rd_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse   (mon_rd_req),
        .pay_in  (mon_radr),
        .clear   (rd_clear),
        .pend    (rd_pend),
        .payload (rd_adr),
        .ovf     (rd_ovf)
    );

    mon_req_slot #(.PAY_W(WR_PAY_W)) u_wr_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse   (mon_wen),
        .pay_in  ({mon_wadr, mon_wdata, mon_mask}),
        .clear   (wr_clear),
        .pend    (wr_pend),
        .payload (wr_payload),
        .ovf     (wr_ovf)
    );

    assign {wr_adr, wr_data, wr_mask} = wr_payload;
    assign mon_ovf = rd_ovf | wr_ovf;

    // NOTE: every output of this block is assigned on every path, so no latch.
    always_comb begin
        cpu_cand  = dc_req & ~dc_done;   // CPU drops dc_req while dc_done is high
        mon_pend  = wr_pend | rd_pend;
        grant_mon = (state == IDLE) & mon_pend & (~cpu_cand | ~last_mon);
        grant_cpu = (state == IDLE) & cpu_cand & ~grant_mon;
        wr_clear  = grant_mon & wr_pend;
        rd_clear  = grant_mon & ~wr_pend;
        wdog_hit  = (TMO_CYC != 0) && (cnt == CNT_W'(TMO_CYC - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            last_mon         <= 1'b0;
            cnt              <= '0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_adr          <= '0;
            mem_wdata        <= '0;
            mem_mask         <= '0;
            dc_done          <= 1'b0;
            dc_rdata         <= '0;
            mon_read_valid   <= 1'b0;
            mon_finish_wresp <= 1'b0;
            mon_rdata        <= '0;
            tmo_err          <= 1'b0;
        end else begin
            mem_req          <= 1'b0;
            dc_done          <= 1'b0;
            mon_read_valid   <= 1'b0;
            mon_finish_wresp <= 1'b0;
            tmo_err          <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_mon) begin
                        state    <= BUSY_MON;
                        last_mon <= 1'b1;
                        mem_req  <= 1'b1;
                        if (wr_pend) begin
                            mem_we    <= 1'b1;
                            mem_adr   <= wr_adr;
                            mem_wdata <= wr_data;
                            mem_mask  <= wr_mask;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_adr   <= rd_adr;
                            mem_wdata <= '0;
                            mem_mask  <= RD_MASK;
                        end
                    end else if (grant_cpu) begin
                        state     <= BUSY_CPU;
                        last_mon  <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_we    <= dc_we;
                        mem_adr   <= dc_adr;
                        mem_wdata <= dc_we ? dc_wdata : '0;
                        mem_mask  <= dc_we ? dc_mask : RD_MASK;
                    end
                end

                BUSY_CPU, BUSY_MON: begin
                    cnt <= cnt + CNT_W'(1);
                    // A watchdog abort completes the owner with zero read data.
                    if (mem_ack || wdog_hit) begin
                        state   <= IDLE;
                        tmo_err <= ~mem_ack;
                        if (state == BUSY_CPU) begin
                            dc_done <= 1'b1;
                            if (!mem_we) dc_rdata <= mem_ack ? mem_rdata : '0;
                        end else if (mem_we) begin
                            mon_finish_wresp <= 1'b1;
                        end else begin
                            mon_read_valid <= 1'b1;
                            mon_rdata      <= mem_ack ? mem_rdata : '0;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: a scoreboard of expected RAM
// transactions and completions plus per-scenario timing checks.
module tb_dram_port_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mon_rd_req, mon_wen;
    logic [31:0]  mon_radr, mon_wadr;
    logic [127:0] mon_wdata;
    logic [15:0]  mon_mask;
    logic         mon_read_valid, mon_finish_wresp, mon_ovf;
    logic [127:0] mon_rdata;
    logic         dc_req, dc_we;
    logic [31:0]  dc_adr;
    logic [127:0] dc_wdata;
    logic [15:0]  dc_mask;
    logic         dc_done;
    logic [127:0] dc_rdata;
    logic         mem_req, mem_we;
    logic [31:0]  mem_adr;
    logic [127:0] mem_wdata;
    logic [15:0]  mem_mask;
    logic         mem_ack;
    logic [127:0] mem_rdata;
    logic         tmo_err;

    int tests = 0;
    int fails = 0;

    // responder controls
    bit ack_en    = 1'b1;
    int ack_delay = 3;
    int ack_wait  = 0;
    bit late_ack  = 1'b0;

    typedef struct {
        logic [2:0]   done_sel;   // {dc_done, mon_read_valid, mon_finish_wresp}
        logic         we;
        logic [31:0]  adr;
        logic [127:0] wdata;
        logic [15:0]  mask;
        logic [127:0] rdata;
        logic         tmo;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    bit   cur_v = 1'b0;

    localparam logic [2:0] SEL_CPU = 3'b100;
    localparam logic [2:0] SEL_MRD = 3'b010;
    localparam logic [2:0] SEL_MWR = 3'b001;

    dram_port_arbiter #(.TMO_CYC(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mon_rd_req       (mon_rd_req),
        .mon_radr         (mon_radr),
        .mon_wen          (mon_wen),
        .mon_wadr         (mon_wadr),
        .mon_wdata        (mon_wdata),
        .mon_mask         (mon_mask),
        .mon_read_valid   (mon_read_valid),
        .mon_rdata        (mon_rdata),
        .mon_finish_wresp (mon_finish_wresp),
        .mon_ovf          (mon_ovf),
        .dc_req           (dc_req),
        .dc_we            (dc_we),
        .dc_adr           (dc_adr),
        .dc_wdata         (dc_wdata),
        .dc_mask          (dc_mask),
        .dc_done          (dc_done),
        .dc_rdata         (dc_rdata),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_adr          (mem_adr),
        .mem_wdata        (mem_wdata),
        .mem_mask         (mem_mask),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .tmo_err          (tmo_err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] data_for(input logic [31:0] adr);
        if (adr == 32'h0000_1230) return {16{8'hA5}};
        return {4{adr ^ 32'hC3C3_5A5A}};
    endfunction

    function automatic void push_txn(input logic [2:0] sel, input logic we,
                                     input logic [31:0] adr, input logic [127:0] wdata,
                                     input logic [15:0] mask, input logic tmo);
        txn_t t;
        t.done_sel = sel;
        t.we       = we;
        t.adr      = adr;
        t.wdata    = we ? wdata : 128'h0;
        t.mask     = we ? mask : 16'hffff;
        t.rdata    = tmo ? 128'h0 : data_for(adr);
        t.tmo      = tmo;
        exp_q.push_back(t);
    endfunction

    // RAM controller model: acks ack_delay cycles after mem_req, driven on negedge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '1;
        forever begin
            @(negedge clk);
            mem_ack   = late_ack;
            late_ack  = 1'b0;
            mem_rdata = '1;
            if (!rst_n) begin
                ack_wait = 0;
            end else if (mem_req) begin
                ack_wait = ack_delay;
            end else if (ack_wait != 0) begin
                ack_wait--;
                if (ack_wait == 0 && ack_en) begin
                    mem_ack   = 1'b1;
                    mem_rdata = data_for(mem_adr);
                end
            end
        end
    end

    // Scoreboard: pop an expected transaction per mem_req, check its completion.
    initial begin
        logic [127:0] got_rdata;
        forever begin
            @(posedge clk); #1;
            if (rst_n === 1'b1) begin
                if (dc_done || mon_read_valid || mon_finish_wresp) begin
                    tests++;
                    if (!cur_v) begin
                        fails++;
                        $display("FAIL sb_done: done pulses %b with nothing outstanding, required none",
                                 {dc_done, mon_read_valid, mon_finish_wresp});
                    end else begin
                        got_rdata = dc_done ? dc_rdata : mon_rdata;
                        if ({dc_done, mon_read_valid, mon_finish_wresp, tmo_err} !== {cur.done_sel, cur.tmo} ||
                            (!cur.we && got_rdata !== cur.rdata)) begin
                            fails++;
                            $display("FAIL sb_done adr=%h: sel/tmo=%b rdata=%h, required %b rdata=%h",
                                     cur.adr, {dc_done, mon_read_valid, mon_finish_wresp, tmo_err}, got_rdata,
                                     {cur.done_sel, cur.tmo}, cur.rdata);
                        end
                        cur_v = 1'b0;
                    end
                end
                if (mem_req) begin
                    tests++;
                    if (cur_v || exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL sb_req: mem_req adr=%h while outstanding=%0d queued=%0d, required none",
                                 mem_adr, cur_v, exp_q.size());
                    end else begin
                        cur   = exp_q.pop_front();
                        cur_v = 1'b1;
                        if ({mem_we, mem_adr, mem_wdata, mem_mask} !== {cur.we, cur.adr, cur.wdata, cur.mask}) begin
                            fails++;
                            $display("FAIL sb_req: we=%b adr=%h wdata=%h mask=%h, required we=%b adr=%h wdata=%h mask=%h",
                                     mem_we, mem_adr, mem_wdata, mem_mask, cur.we, cur.adr, cur.wdata, cur.mask);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        mon_rd_req = 1'b0; mon_radr = '0;
        mon_wen    = 1'b0; mon_wadr = '0; mon_wdata = '0; mon_mask = '0;
        dc_req     = 1'b0; dc_we = 1'b0; dc_adr = '0; dc_wdata = '0; dc_mask = '0;
        exp_q.delete();
        cur_v = 1'b0;
        tick(3);
        rst_n = 1'b1;
    endtask

    task automatic mon_read(input logic [31:0] adr);
        mon_rd_req = 1'b1; mon_radr = adr;
        tick(1);
        mon_rd_req = 1'b0;
    endtask

    task automatic mon_write(input logic [31:0] adr, input logic [127:0] data, input logic [15:0] mask);
        mon_wen = 1'b1; mon_wadr = adr; mon_wdata = data; mon_mask = mask;
        tick(1);
        mon_wen = 1'b0;
    endtask

    task automatic wait_mem_req(output bit ok);
        int n = 0;
        while (!mem_req && n < 50) begin
            tick(1);
            n++;
        end
        ok = mem_req;
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        while ((exp_q.size() != 0 || cur_v) && n < 300) begin
            tick(1);
            n++;
        end
        ok = (exp_q.size() == 0 && !cur_v);
        tick(2);
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if ({mem_req, mem_we, mem_adr, mem_wdata, mem_mask, dc_done, dc_rdata, mon_read_valid,
             mon_rdata, mon_finish_wresp, mon_ovf, tmo_err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: some output nonzero (mem_adr=%h mem_mask=%h), required all 0",
                     mem_adr, mem_mask);
        end
        tick(3);
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: mem_req=%b with no requests, required 0", mem_req);
        end
    endtask

    task automatic test_mon_read();
        int  n;
        bit  ok;
        ack_en = 1'b1; ack_delay = 3;
        push_txn(SEL_MRD, 1'b0, 32'h0000_1230, '0, '0, 1'b0);
        mon_read(32'h0000_1230);                 // now cycle N+1
        tests++;
        if (mem_req !== 1'b0) begin
            fails++; $display("FAIL rd_early: mem_req=%b in N+1, required 0", mem_req);
        end
        tick(1);                                  // N+2
        tests++;
        if ({mem_req, mem_we, mem_adr, mem_mask} !== {1'b1, 1'b0, 32'h0000_1230, 16'hffff}) begin
            fails++;
            $display("FAIL rd_issue: req=%b we=%b adr=%h mask=%h, required 1 0 00001230 ffff",
                     mem_req, mem_we, mem_adr, mem_mask);
        end
        tick(1);
        tests++;
        if (mem_req !== 1'b0) begin
            fails++; $display("FAIL rd_req_pulse: mem_req=%b in N+3, required 0", mem_req);
        end
        n = 1;
        while (!mon_read_valid && n < 20) begin
            tick(1); n++;
        end
        tests++;
        if (n !== 4) begin
            fails++; $display("FAIL rd_latency: done %0d cycles after mem_req, required 4", n);
        end
        tests++;
        if (mon_rdata !== {16{8'hA5}}) begin
            fails++; $display("FAIL rd_data: mon_rdata=%h, required %h", mon_rdata, {16{8'hA5}});
        end
        tick(1);
        tests++;
        if (mon_read_valid !== 1'b0) begin
            fails++; $display("FAIL rd_valid_pulse: mon_read_valid=%b, required 0", mon_read_valid);
        end
        drain(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL rd_drain: scoreboard not empty, required empty"); end
    endtask

    task automatic test_mon_write();
        bit ok;
        ack_en = 1'b1; ack_delay = 3;
        push_txn(SEL_MWR, 1'b1, 32'h0000_2000, {4{32'hdeadbeef}}, 16'hf0ff, 1'b0);
        mon_write(32'h0000_2000, {4{32'hdeadbeef}}, 16'hf0ff);
        wait_mem_req(ok);
        tests++;
        if (!ok || mem_we !== 1'b1 || mem_mask !== 16'hf0ff) begin
            fails++;
            $display("FAIL wr_issue: seen=%b we=%b mask=%h, required 1 1 f0ff", ok, mem_we, mem_mask);
        end
        tick(3);                                  // ack cycle
        tests++;
        if (mon_finish_wresp !== 1'b0) begin
            fails++; $display("FAIL wr_early: mon_finish_wresp=%b in ack cycle, required 0", mon_finish_wresp);
        end
        tick(1);
        tests++;
        if (mon_finish_wresp !== 1'b1) begin
            fails++; $display("FAIL wr_done: mon_finish_wresp=%b after ack, required 1", mon_finish_wresp);
        end
        tick(1);
        tests++;
        if (mon_finish_wresp !== 1'b0) begin
            fails++; $display("FAIL wr_pulse: mon_finish_wresp=%b, required 0", mon_finish_wresp);
        end
        drain(ok);
    endtask

    task automatic test_back_to_back();
        int cpu_i = 0, mon_i = 1, mon_done = 0, n = 0;
        bit ok;
        apply_reset();
        ack_en = 1'b1; ack_delay = 1;
        for (int i = 0; i < 4; i++) begin
            push_txn(SEL_MRD, 1'b0, 32'h0000_3000 + 32'(i * 16), '0, '0, 1'b0);
            push_txn(SEL_CPU, (i % 2 == 1), 32'h0000_4000 + 32'(i * 16),
                     {4{32'h1111_0000 + 32'(i)}}, 16'h0f0f ^ 16'(i), 1'b0);
        end
        mon_read(32'h0000_3000);
        dc_we = 1'b0; dc_adr = 32'h0000_4000; dc_wdata = {4{32'h1111_0000}}; dc_mask = 16'h0f0f;
        dc_req = 1'b1;
        while ((cpu_i < 4 || mon_done < 4) && n < 400) begin
            tick(1); n++;
            mon_rd_req = 1'b0;
            if (dc_done) begin
                dc_req = 1'b0; cpu_i++;
            end else if (!dc_req && cpu_i < 4) begin
                dc_we    = (cpu_i % 2 == 1);
                dc_adr   = 32'h0000_4000 + 32'(cpu_i * 16);
                dc_wdata = {4{32'h1111_0000 + 32'(cpu_i)}};
                dc_mask  = 16'h0f0f ^ 16'(cpu_i);
                dc_req   = 1'b1;
            end
            if (mon_read_valid) mon_done++;
            // refill the read slot as soon as its previous request is granted
            if (mem_req && mem_adr[15:12] == 4'h3 && mon_i < 4) begin
                mon_rd_req = 1'b1;
                mon_radr   = 32'h0000_3000 + 32'(mon_i * 16);
                mon_i++;
            end
        end
        mon_rd_req = 1'b0;
        tests++;
        if (cpu_i !== 4 || mon_done !== 4) begin
            fails++;
            $display("FAIL b2b_count: cpu=%0d mon=%0d completions, required 4 and 4", cpu_i, mon_done);
        end
        drain(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL b2b_drain: scoreboard not empty, required empty"); end
    endtask

    task automatic test_overflow();
        int n = 0;
        bit ok;
        ack_en = 1'b1; ack_delay = 3;
        tests++;
        if (mon_ovf !== 1'b0) begin
            fails++; $display("FAIL ovf_init: mon_ovf=%b, required 0", mon_ovf);
        end
        push_txn(SEL_CPU, 1'b0, 32'h0000_6000, '0, '0, 1'b0);
        push_txn(SEL_MRD, 1'b0, 32'h0000_6100, '0, '0, 1'b0);
        push_txn(SEL_MRD, 1'b0, 32'h0000_6200, '0, '0, 1'b0);
        push_txn(SEL_MRD, 1'b0, 32'h0000_6300, '0, '0, 1'b0);
        dc_we = 1'b0; dc_adr = 32'h0000_6000; dc_req = 1'b1;
        tick(1);
        mon_read(32'h0000_6100);
        while (!dc_done && n < 50) begin
            tick(1); n++;
        end
        // pulse coincides with the grant of the pending read
        dc_req = 1'b0;
        mon_read(32'h0000_6200);
        tests++;
        if (mon_ovf !== 1'b0) begin
            fails++; $display("FAIL ovf_coincide: mon_ovf=%b after pulse on grant, required 0", mon_ovf);
        end
        n = 0;
        while (!(mem_req && mem_adr == 32'h0000_6200) && n < 50) begin
            tick(1); n++;
        end
        mon_read(32'h0000_6300);
        mon_read(32'h0000_6400);                  // slot full, not granted: dropped
        tests++;
        if (mon_ovf !== 1'b1) begin
            fails++; $display("FAIL ovf_set: mon_ovf=%b after dropped pulse, required 1", mon_ovf);
        end
        drain(ok);
        tick(5);
        tests++;
        if (!ok || mon_ovf !== 1'b1) begin
            fails++; $display("FAIL ovf_sticky: drained=%b mon_ovf=%b, required 1 1", ok, mon_ovf);
        end
    endtask

    task automatic test_timeout();
        int  n = 0;
        bit  ok, seen = 1'b0;
        ack_en = 1'b0; ack_delay = 3;
        push_txn(SEL_CPU, 1'b0, 32'h0000_5000, '0, '0, 1'b1);
        dc_we = 1'b0; dc_adr = 32'h0000_5000; dc_req = 1'b1;
        wait_mem_req(ok);
        while (!tmo_err && n < 20) begin
            tick(1); n++;
        end
        tests++;
        if (n !== 4 || dc_done !== 1'b1 || dc_rdata !== 128'h0) begin
            fails++;
            $display("FAIL tmo_abort: tmo_err after %0d cycles done=%b rdata=%h, required 4 1 0",
                     n, dc_done, dc_rdata);
        end
        dc_req = 1'b0;
        tick(1);
        late_ack = 1'b1;
        repeat (6) begin
            tick(1);
            seen |= dc_done | mon_read_valid | mon_finish_wresp | mem_req | tmo_err;
        end
        tests++;
        if (seen !== 1'b0 || dc_rdata !== 128'h0) begin
            fails++;
            $display("FAIL tmo_late_ack: activity=%b dc_rdata=%h, required 0 0", seen, dc_rdata);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok, seen = 1'b0;
        ack_en = 1'b1; ack_delay = 6;
        push_txn(SEL_MWR, 1'b1, 32'h0000_7000, {4{32'hcafe_f00d}}, 16'h0000, 1'b0);
        mon_write(32'h0000_7000, {4{32'hcafe_f00d}}, 16'h0000);
        wait_mem_req(ok);
        tick(1);
        rst_n = 1'b0;
        exp_q.delete();
        cur_v = 1'b0;
        #1;
        tests++;
        if (!ok || {mem_req, mem_we, mem_adr, mem_wdata, mem_mask, dc_done, dc_rdata, mon_read_valid,
                    mon_rdata, mon_finish_wresp, mon_ovf, tmo_err} !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs: busy=%b mem_we=%b mem_adr=%h mon_ovf=%b, required 1 0 0 0",
                     ok, mem_we, mem_adr, mon_ovf);
        end
        @(posedge clk); #1;
        tick(1);
        rst_n = 1'b1;
        repeat (10) begin
            tick(1);
            seen |= dc_done | mon_read_valid | mon_finish_wresp | mem_req | tmo_err;
        end
        tests++;
        if (seen !== 1'b0 || mon_ovf !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_stale: activity=%b mon_ovf=%b after release, required 0 0", seen, mon_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_mon_read();
        test_mon_write();
        test_back_to_back();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
